// File: rtl/video_fetch_timing_if.sv
// Framebuffer word-fetch port: the timing block requests 32-bit words by address,
// and the memory side answers with ack plus data.
interface video_fetch_timing_if;
   logic        fetch_req;
   logic [23:0] fetch_addr;
   logic        fetch_ack;
   logic [31:0] fetch_data;

   modport master (output fetch_req, output fetch_addr, input fetch_ack, input fetch_data);
   modport slave  (input fetch_req, input fetch_addr, output fetch_ack, output fetch_data);
endinterface

// File: rtl/video_fetch_timing.sv
// Raster timing generator plus 1 bpp framebuffer streamer for a vga2dvid front end.
// One shifting word and one prefetched hold word; all video outputs registered.
module video_fetch_timing #(
   parameter int          C_resolution_x      = 1024,
   parameter int          C_hsync_front_porch = 16,
   parameter int          C_hsync_pulse       = 96,
   parameter int          C_hsync_back_porch  = 44,
   parameter int          C_resolution_y      = 768,
   parameter int          C_vsync_front_porch = 10,
   parameter int          C_vsync_pulse       = 2,
   parameter int          C_vsync_back_porch  = 31,
   parameter int          C_bits_x            = 11,
   parameter int          C_bits_y            = 11,
   parameter logic [23:0] C_base_addr         = 24'h039FC0
) (
   input  logic                 i_clk_pixel,
   input  logic                 i_rstn,
   video_fetch_timing_if.master fetch,
   output logic [1:0]           o_vga_r,
   output logic [1:0]           o_vga_g,
   output logic [1:0]           o_vga_b,
   output logic                 o_vga_hsync,
   output logic                 o_vga_vsync,
   output logic                 o_vga_blank,
   output logic                 o_underrun,
   output logic                 o_frame_start
);

   localparam int L_HT    = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
   localparam int L_VT    = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
   localparam int L_WORDS = C_resolution_x * C_resolution_y / 32;
   localparam int L_CW    = $clog2(L_WORDS + 1);

   localparam logic [C_bits_x-1:0] L_X_LAST = C_bits_x'(L_HT - 1);
   localparam logic [C_bits_x-1:0] L_X_ACT  = C_bits_x'(C_resolution_x);
   localparam logic [C_bits_x-1:0] L_HS_ON  = C_bits_x'(C_resolution_x + C_hsync_front_porch);
   localparam logic [C_bits_x-1:0] L_HS_OFF = C_bits_x'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
   localparam logic [C_bits_y-1:0] L_Y_LAST = C_bits_y'(L_VT - 1);
   localparam logic [C_bits_y-1:0] L_Y_ACT  = C_bits_y'(C_resolution_y);
   localparam logic [C_bits_y-1:0] L_VS_ON  = C_bits_y'(C_resolution_y + C_vsync_front_porch);
   localparam logic [C_bits_y-1:0] L_VS_OFF = C_bits_y'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
   localparam logic [L_CW-1:0]     L_WORDS_C = L_CW'(L_WORDS);

   logic [C_bits_x-1:0] r_x;
   logic [C_bits_y-1:0] r_y;
   logic                r_req;
   logic [23:0]         r_addr;
   logic [L_CW-1:0]     r_count;
   logic [31:0]         r_hold;
   logic                r_hold_valid;
   logic [31:0]         r_shift;
   logic                r_discard;
   logic [1:0]          r_rgb;
   logic                r_hsync;
   logic                r_vsync;
   logic                r_blank;
   logic                r_underrun;
   logic                r_frame_start;

   logic        w_active;
   logic        w_slot;
   logic        w_restart;
   logic        w_xfer;
   logic [31:0] w_word;
   logic        w_pixel;

   assign w_active  = (r_x < L_X_ACT) && (r_y < L_Y_ACT);
   assign w_slot    = w_active && (r_x[4:0] == 5'd0);
   assign w_restart = (r_x == '0) && (r_y == L_Y_ACT);
   assign w_xfer    = r_req && fetch.fetch_ack;
   // An empty hold at a word boundary yields a blank 32-pixel slot rather than a refetch.
   assign w_word    = r_hold_valid ? r_hold : 32'd0;
   assign w_pixel   = w_slot ? w_word[0] : r_shift[0];

   always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
      if (!i_rstn) begin
         r_x <= '0;
         r_y <= '0;
      end else if (r_x == L_X_LAST) begin
         r_x <= '0;
         r_y <= (r_y == L_Y_LAST) ? '0 : r_y + 1'b1;
      end else begin
         r_x <= r_x + 1'b1;
      end
   end

   always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
      if (!i_rstn) begin
         r_req        <= 1'b0;
         r_addr       <= C_base_addr;
         r_count      <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_shift      <= '0;
         r_discard    <= 1'b0;
      end else begin
         if (r_req) begin
            if (fetch.fetch_ack) r_req <= 1'b0;
         end else if (!r_hold_valid && (r_count < L_WORDS_C)) begin
            r_req <= 1'b1;
         end

         if (w_slot)        r_shift <= w_word >> 1;
         else if (w_active) r_shift <= r_shift >> 1;

         // A request still in flight at frame restart belongs to the old frame: drop its data.
         if (w_restart) begin
            r_addr       <= C_base_addr;
            r_count      <= '0;
            r_hold_valid <= 1'b0;
            r_discard    <= r_req && !fetch.fetch_ack;
         end else begin
            if (w_xfer && !r_discard) begin
               r_hold       <= fetch.fetch_data;
               r_hold_valid <= 1'b1;
               r_addr       <= r_addr + 24'd1;
               r_count      <= r_count + 1'b1;
            end else if (w_slot) begin
               r_hold_valid <= 1'b0;
            end
            if (w_xfer) r_discard <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
      if (!i_rstn) begin
         r_rgb         <= 2'b00;
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_blank       <= 1'b1;
         r_underrun    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_rgb         <= (w_active && w_pixel) ? 2'b11 : 2'b00;
         r_hsync       <= (r_x >= L_HS_ON) && (r_x < L_HS_OFF);
         r_vsync       <= (r_y >= L_VS_ON) && (r_y < L_VS_OFF);
         r_blank       <= !w_active;
         r_underrun    <= w_slot && !r_hold_valid;
         r_frame_start <= (r_x == '0) && (r_y == '0);
      end
   end

   assign fetch.fetch_req  = r_req;
   assign fetch.fetch_addr = r_addr;
   assign o_vga_r          = r_rgb;
   assign o_vga_g          = r_rgb;
   assign o_vga_b          = r_rgb;
   assign o_vga_hsync      = r_hsync;
   assign o_vga_vsync      = r_vsync;
   assign o_vga_blank      = r_blank;
   assign o_underrun       = r_underrun;
   assign o_frame_start    = r_frame_start;

endmodule
